// File: rtl/load_store_unit.sv
// Load/store stage: one outstanding word-wide memory access, with lane steering and load extension.
// Optional wait-cycle timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    logic        misaligned;
    logic [3:0]  strb;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Alignment check and store lane steering on the live request inputs.
    always_comb begin
        misaligned = 1'b0;
        strb       = 4'b1111;
        lane_wdata = wdata;
        case (size)
            2'b00: begin
                strb       = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                strb       = 4'b0011 << addr[1:0];
                lane_wdata = {2{wdata[15:0]}};
            end
            2'b10: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Load extraction uses the captured offset/size, since the inputs are free while busy.
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
`ifdef LSU_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_lo_d = addr[1:0];
                    size_d    = size;
                    uns_d     = is_unsigned;
                    if (misaligned) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = is_store ? strb : 4'b0000;
                        mem_wdata_d = lane_wdata;
                        fault_d     = 1'b0;
`ifdef LSU_TIMEOUT_EN
                        wait_d      = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = 1'b0;
                    if (!mem_we_q)
                        rdata_d = ld_ext;
                end
`ifdef LSU_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_lo_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU wiring stage.
- Takes the ALU sum as the effective address and rs2 as store data for SW/SH/SB/LW/LH/LB/LHU/LBU.
- Runs a request/ready handshake with a word-wide data memory.
- Returns an aligned, sign- or zero-extended load result, or a misalignment fault, to writeback.

Parameters:
- ADDR_W, 32, width of the address in and out of the block.
- TIMEOUT_CYCLES, 64, wait-cycle limit used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins an access; accepted only when busy=0.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- is_unsigned  in  1  1 = zero-extend a load (LBU/LHU); ignored for words and stores.
- addr  in  ADDR_W  effective address (ALU out).
- wdata  in  32  store data (rs2).
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable, valid while mem_req=1.
- mem_addr  out  ADDR_W  word-aligned address, addr with bits [1:0] forced to 0.
- mem_wstrb  out  4  byte lanes to write.
- mem_wdata  out  32  store data shifted into the addressed lane(s).
- mem_ready  in  1  memory accepted the request (write) or rdata is valid (read).
- mem_rdata  in  32  read word.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = misaligned or illegal size (or timeout when enabled).
- rdata  out  32  extended load result; held until the next done.

Behaviour:
- Reset: state=IDLE. mem_req, mem_we, done, fault = 0. mem_addr, mem_wstrb, mem_wdata, rdata = 0. Any in-flight access is abandoned, and a mem_ready arriving the cycle after reset is ignored.
- Captured registers: start with busy=0 loads addr, size, is_store, is_unsigned, wdata. Inputs are don't-care while busy=1, and start while busy=1 is ignored.
- Misalignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - size=11 is illegal.
- FSM state IDLE:
  - start with an aligned access -> ACCESS; mem_req=1 from the next cycle.
  - start with a misaligned access -> RESP with fault=1; no memory request is issued.
- FSM state ACCESS:
  - mem_req=1. mem_addr, mem_we, mem_wstrb, mem_wdata stay stable until mem_ready.
  - On the cycle mem_ready=1: a load latches the extracted mem_rdata into rdata. Next state is RESP, and mem_req drops to 0 in that next cycle.
  - mem_ready=0 holds ACCESS indefinitely, unless timeout is enabled.
- FSM state RESP:
  - done=1 for exactly one cycle, fault as determined, then -> IDLE.
  - Back-to-back start is accepted in the cycle after RESP (busy=0).
- Strobes and write-lane placement:
  - byte: wstrb = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: wstrb = 0011 << addr[1:0]; mem_wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111; mem_wdata = wdata.
  - Loads drive wstrb = 0000 and mem_we = 0.
- Load extraction:
  - byte = mem_rdata[8*addr[1:0] +: 8].
  - half = mem_rdata[16*addr[1] +: 16].
  - Sign-extend unless is_unsigned=1.
- Stores: rdata is unchanged.
- Fault responses: rdata is unchanged.
- Latency:
  - Aligned access: start at cycle 0; mem_req in cycles 1..N, where N is the first cycle with mem_ready=1; done at N+1. Minimum latency is 2 cycles.
  - Misaligned access: done at cycle 1.
- Simultaneous reset and mem_ready: reset wins.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each cycle mem_ready=0.
  - When it reaches TIMEOUT_CYCLES-1 while mem_ready is still 0, the request is dropped and the FSM goes to RESP with fault=1.
  - mem_ready on that same cycle takes priority (normal completion, fault=0).
- Undefined: no counter logic; ACCESS waits forever.

Test Plan:
- Word load: start, addr=0x100, size=10, mem_ready on the first request cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000, done at cycle 2, rdata=0xDEADBEEF, fault=0.
- Signed byte load: addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80. Same access with is_unsigned=1 -> rdata=0x00000080.
- Half store: addr=0x102, wdata=0x0000ABCD, mem_ready delayed 3 cycles -> mem_addr=0x100, wstrb=1100, mem_wdata=0xABCDABCD stable for 3 cycles, done one cycle after mem_ready.
- Misaligned word: addr=0x101, size=10 -> no mem_req, done=1 and fault=1 at cycle 1. size=11 gives the same response.
- Reset mid-access: assert reset while in ACCESS -> next cycle mem_req=0, busy=0, done=0. A later mem_ready is ignored, and a new start is accepted normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4: mem_ready held 0 -> mem_req high exactly 4 cycles, then done=1, fault=1.
